// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Two-port round-robin byte arbiter feeding an 8N1 UART transmitter.
// Revision    : 1.0 - initial release
// ============================================================================

module uart_tx_arbiter #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              uart_tx,
  output logic              busy,
  output logic              grant_id
);

  localparam int              CNT_W      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       C_IDX_LAST = 3'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_baud_cnt;
  logic [CNT_W-1:0]   w_baud_cnt_nxt;
  logic [2:0]         r_bit_idx;
  logic [2:0]         w_bit_idx_nxt;
  logic [DATA_W-1:0]  r_shift;
  logic [DATA_W-1:0]  w_shift_nxt;
  logic               r_tx;
  logic               w_tx_nxt;
  logic               r_busy;
  logic               r_grant_id;
  logic               w_grant_id_nxt;
  logic               r_last_grant;
  logic               w_last_grant_nxt;
  logic               w_winner;
  logic               w_accept;
  logic               w_bit_done;

  // On a tie the port that did not win last time goes first.
  always_comb begin
    w_winner = 1'b0;
    if (req0_valid && req1_valid) begin
      w_winner = ~r_last_grant;
    end else if (req1_valid) begin
      w_winner = 1'b1;
    end
  end

  assign req0_ready = (r_state == S_IDLE) & req0_valid & ~w_winner;
  assign req1_ready = (r_state == S_IDLE) & req1_valid &  w_winner;
  assign w_accept   = req0_ready | req1_ready;
  assign w_bit_done = (r_baud_cnt == C_CNT_LAST);

  always_comb begin
    w_state_nxt      = r_state;
    w_baud_cnt_nxt   = r_baud_cnt;
    w_bit_idx_nxt    = r_bit_idx;
    w_shift_nxt      = r_shift;
    w_tx_nxt         = r_tx;
    w_grant_id_nxt   = r_grant_id;
    w_last_grant_nxt = r_last_grant;

    case (r_state)
      S_IDLE: begin
        w_tx_nxt = 1'b1;
        if (w_accept) begin
          w_state_nxt      = S_START;
          w_baud_cnt_nxt   = '0;
          w_bit_idx_nxt    = 3'd0;
          w_shift_nxt      = w_winner ? req1_data : req0_data;
          w_tx_nxt         = 1'b0;
          w_grant_id_nxt   = w_winner;
          w_last_grant_nxt = w_winner;
        end
      end

      S_START: begin
        if (w_bit_done) begin
          w_state_nxt    = S_DATA;
          w_baud_cnt_nxt = '0;
          w_bit_idx_nxt  = 3'd0;
          w_tx_nxt       = r_shift[0];
        end else begin
          w_baud_cnt_nxt = r_baud_cnt + 1'b1;
        end
      end

      S_DATA: begin
        if (w_bit_done) begin
          w_baud_cnt_nxt = '0;
          w_shift_nxt    = r_shift >> 1;
          if (r_bit_idx == C_IDX_LAST) begin
            w_state_nxt = S_STOP;
            w_tx_nxt    = 1'b1;
          end else begin
            // r_shift[1] is the bit that becomes LSB after this shift.
            w_bit_idx_nxt = r_bit_idx + 3'd1;
            w_tx_nxt      = r_shift[1];
          end
        end else begin
          w_baud_cnt_nxt = r_baud_cnt + 1'b1;
        end
      end

      S_STOP: begin
        w_tx_nxt = 1'b1;
        if (w_bit_done) begin
          w_state_nxt    = S_IDLE;
          w_baud_cnt_nxt = '0;
        end else begin
          w_baud_cnt_nxt = r_baud_cnt + 1'b1;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_tx_nxt    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_baud_cnt   <= '0;
      r_bit_idx    <= 3'd0;
      r_shift      <= '0;
      r_tx         <= 1'b1;
      r_busy       <= 1'b0;
      r_grant_id   <= 1'b0;
      r_last_grant <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_baud_cnt   <= w_baud_cnt_nxt;
      r_bit_idx    <= w_bit_idx_nxt;
      r_shift      <= w_shift_nxt;
      r_tx         <= w_tx_nxt;
      r_busy       <= (w_state_nxt != S_IDLE);
      r_grant_id   <= w_grant_id_nxt;
      r_last_grant <= w_last_grant_nxt;
    end
  end

  assign uart_tx  = r_tx;
  assign busy     = r_busy;
  assign grant_id = r_grant_id;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Self-checking bench for uart_tx_arbiter with CLKS_PER_BIT = 4.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_uart_tx_arbiter;

  localparam int CPB = 4;
  localparam int FRAME_CYCLES = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid = 1'b0;
  logic [7:0] req0_data = 8'h00;
  logic       req0_ready;
  logic       req1_valid = 1'b0;
  logic [7:0] req1_data = 8'h00;
  logic       req1_ready;
  logic       uart_tx;
  logic       busy;
  logic       grant_id;

  int checks = 0;
  int errors = 0;
  logic model_last = 1'b1;

  uart_tx_arbiter #(
    .CLKS_PER_BIT(CPB),
    .DATA_W      (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0_valid(req0_valid),
    .req0_data (req0_data),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid),
    .req1_data (req1_data),
    .req1_ready(req1_ready),
    .uart_tx   (uart_tx),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Line level expected at bit slot k of an 8N1 frame carrying d.
  function automatic logic frame_bit(input logic [7:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return d[k-1];
  endfunction

  // Round-robin rule written from the arbitration description.
  function automatic logic model_pick(input logic v0, input logic v1, input logic last);
    if (v0 && v1) return (last == 1'b0) ? 1'b1 : 1'b0;
    return v1;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_last = 1'b1;
    @(negedge clk);
  endtask

  // Called at a negedge with inputs already set; expects a grant within
  // max_wait cycles, then checks all 40 frame cycles and the idle cycle after.
  task automatic check_frame(input logic [7:0] d, input logic p, input bit drop,
                             input int max_wait, input string tag);
    bit got = 1'b0;
    for (int n = 0; n < max_wait && !got; n++) begin
      #1;
      if (req0_ready || req1_ready) got = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s grant_wait: no ready within %0d cycles", tag, max_wait);
      return;
    end
    checks++;
    if ({req1_ready, req0_ready} !== (p ? 2'b10 : 2'b01)) begin
      errors++;
      $display("FAIL %s grant_port: ready1/0=%b%b required port %0d", tag, req1_ready, req0_ready, p);
    end
    model_last = p;
    @(posedge clk);
    @(negedge clk);
    if (drop) begin
      if (p) req1_valid = 1'b0;
      else   req0_valid = 1'b0;
    end
    for (int i = 0; i < FRAME_CYCLES; i++) begin
      checks++;
      if (uart_tx !== frame_bit(d, i / CPB)) begin
        errors++;
        $display("FAIL %s line cycle %0d: uart_tx=%b required %b", tag, i, uart_tx, frame_bit(d, i / CPB));
      end
      checks++;
      if (busy !== 1'b1 || grant_id !== p || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s status cycle %0d: busy=%b grant_id=%b rdy=%b%b required 1 %0d 00",
                 tag, i, busy, grant_id, req1_ready, req0_ready, p);
      end
      @(negedge clk);
    end
    checks++;
    if (busy !== 1'b0 || uart_tx !== 1'b1) begin
      errors++;
      $display("FAIL %s idle_after: busy=%b uart_tx=%b required 0 1", tag, busy, uart_tx);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (grant_id !== 1'b0) begin
      errors++;
      $display("FAIL reset_grant_id: got %b required 0", grant_id);
    end
    for (int i = 0; i < 50; i++) begin
      #1;
      checks++;
      if (uart_tx !== 1'b1 || busy !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: tx=%b busy=%b rdy=%b%b required 1 0 00",
                 i, uart_tx, busy, req1_ready, req0_ready);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_single();
    apply_reset();
    req0_data  = 8'hA5;
    req0_valid = 1'b1;
    check_frame(8'hA5, 1'b0, 1'b1, 5, "single_a5");
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++;
      if (req0_ready !== 1'b0 || busy !== 1'b0 || uart_tx !== 1'b1 || grant_id !== 1'b0) begin
        errors++;
        $display("FAIL single_after cycle %0d: rdy0=%b busy=%b tx=%b gid=%b required 0 0 1 0",
                 i, req0_ready, busy, uart_tx, grant_id);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    req0_data  = 8'h11;
    req1_data  = 8'h22;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    check_frame(8'h11, 1'b0, 1'b0, 5, "rr_first");
    check_frame(8'h22, 1'b1, 1'b0, 1, "rr_second");
    check_frame(8'h11, 1'b0, 1'b0, 1, "rr_third");
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_late_request();
    logic [7:0] d0;
    apply_reset();
    d0 = 8'($urandom_range(0, 255));
    req1_data  = 8'h5A;
    req1_valid = 1'b1;
    fork
      check_frame(8'h5A, 1'b1, 1'b0, 5, "late_p1");
      begin
        repeat (12) @(negedge clk);
        req0_data  = d0;
        req0_valid = 1'b1;
        req1_data  = 8'hC3;
      end
    join
    check_frame(d0, 1'b0, 1'b1, 1, "late_p0");
    check_frame(8'hC3, 1'b1, 1'b1, 1, "late_p1_again");
  endtask

  task automatic test_reset_mid_frame();
    int stop_at [2] = '{15, 2};
    for (int r = 0; r < 2; r++) begin
      apply_reset();
      req0_data  = 8'h3C;
      req0_valid = 1'b1;
      #1;
      @(posedge clk);
      @(negedge clk);
      req0_valid = 1'b0;
      for (int i = 0; i < stop_at[r]; i++) @(negedge clk);
      checks++;
      if (uart_tx !== frame_bit(8'h3C, stop_at[r] / CPB) || busy !== 1'b1) begin
        errors++;
        $display("FAIL midreset_pre %0d: tx=%b busy=%b required %b 1",
                 stop_at[r], uart_tx, busy, frame_bit(8'h3C, stop_at[r] / CPB));
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (uart_tx !== 1'b1 || busy !== 1'b0 || grant_id !== 1'b0) begin
        errors++;
        $display("FAIL midreset_async %0d: tx=%b busy=%b gid=%b required 1 0 0",
                 stop_at[r], uart_tx, busy, grant_id);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        checks++;
        if (uart_tx !== 1'b1 || busy !== 1'b0) begin
          errors++;
          $display("FAIL midreset_quiet cycle %0d: tx=%b busy=%b required 1 0", i, uart_tx, busy);
        end
      end
    end
  endtask

  task automatic test_extremes();
    apply_reset();
    req1_data  = 8'h00;
    req1_valid = 1'b1;
    check_frame(8'h00, 1'b1, 1'b1, 5, "ext_00");
    req1_data  = 8'hFF;
    req1_valid = 1'b1;
    check_frame(8'hFF, 1'b1, 1'b1, 1, "ext_ff");
  endtask

  task automatic test_random();
    logic v0, v1, w;
    logic [7:0] d0, d1;
    apply_reset();
    for (int t = 0; t < 10; t++) begin
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      if (!v0 && !v1) v0 = 1'b1;
      d0 = 8'($urandom_range(0, 255));
      d1 = 8'($urandom_range(0, 255));
      req0_data  = d0;
      req1_data  = d1;
      req0_valid = v0;
      req1_valid = v1;
      w = model_pick(v0, v1, model_last);
      check_frame(w ? d1 : d0, w, 1'b1, 1, $sformatf("rand_%0d", t));
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_late_request();
    test_reset_mid_frame();
    test_extremes();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
